// File: rtl/div_unit_if.sv
// Request/response bundle between the execute-stage issue logic and the iterative divider.
// The master modport is the issuer; the slave modport is the divider itself.
interface div_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [XLEN-1:0]  dividend;
    logic [XLEN-1:0]  divisor;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output flush, in_valid, op, dividend, divisor, tag_in,
        input  in_ready, out_valid, result, tag_out
    );

    modport slave (
        input  flush, in_valid, op, dividend, divisor, tag_in,
        output in_ready, out_valid, result, tag_out
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved at acceptance without iterating.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
        return (~v) + XLEN'(1);
    endfunction

    state_t           state_r;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  dvs_r;
    logic [XLEN-1:0]  result_r;
    logic [TAG_W-1:0] tag_r;
    logic [TAG_W-1:0] tag_out_r;
    logic [1:0]       op_r;
    logic             sign_q_r;
    logic             sign_r_r;
    logic [CNT_W-1:0] cnt_r;
    logic             out_valid_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             is_signed_s;
    logic             dvd_neg_s;
    logic             dvs_neg_s;
    logic [XLEN-1:0]  dvd_mag_s;
    logic [XLEN-1:0]  dvs_mag_s;
    logic             div_zero_s;
    logic             overflow_s;
    logic [XLEN-1:0]  special_res_s;
    logic [XLEN:0]    shift_s;
    logic [XLEN:0]    diff_s;
    logic [XLEN-1:0]  quo_fix_s;
    logic [XLEN-1:0]  rem_fix_s;

    assign in_ready_s    = (state_r == IDLE) && !bus.flush;
    assign accept_s      = bus.in_valid && in_ready_s;
    assign bus.in_ready  = in_ready_s;
    // The pulse is suppressed combinationally so a flush in the pulse cycle also hides it.
    assign bus.out_valid = out_valid_r && !bus.flush;
    assign bus.result    = result_r;
    assign bus.tag_out   = tag_out_r;

    // Operand decode at acceptance: magnitudes, sign flags and special-case detection.
    always_comb begin
        is_signed_s   = !bus.op[0];
        dvd_neg_s     = is_signed_s && bus.dividend[XLEN-1];
        dvs_neg_s     = is_signed_s && bus.divisor[XLEN-1];
        dvd_mag_s     = dvd_neg_s ? neg2(bus.dividend) : bus.dividend;
        dvs_mag_s     = dvs_neg_s ? neg2(bus.divisor) : bus.divisor;
        div_zero_s    = (bus.divisor == {XLEN{1'b0}});
        overflow_s    = is_signed_s && (bus.dividend == INT_MIN) && (bus.divisor == {XLEN{1'b1}});
        special_res_s = {XLEN{1'b0}};
        if (div_zero_s) begin
            special_res_s = bus.op[1] ? bus.dividend : {XLEN{1'b1}};
        end else if (overflow_s) begin
            special_res_s = bus.op[1] ? {XLEN{1'b0}} : INT_MIN;
        end else begin
            special_res_s = {XLEN{1'b0}};
        end
    end

    // One restoring step; diff_s[XLEN] set means the trial subtraction went negative.
    always_comb begin
        shift_s   = {rem_r, quo_r[XLEN-1]};
        diff_s    = shift_s - {1'b0, dvs_r};
        quo_fix_s = sign_q_r ? neg2(quo_r) : quo_r;
        rem_fix_s = sign_r_r ? neg2(rem_r) : rem_r;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rem_r       <= {XLEN{1'b0}};
            quo_r       <= {XLEN{1'b0}};
            dvs_r       <= {XLEN{1'b0}};
            result_r    <= {XLEN{1'b0}};
            tag_r       <= {TAG_W{1'b0}};
            tag_out_r   <= {TAG_W{1'b0}};
            op_r        <= 2'b00;
            sign_q_r    <= 1'b0;
            sign_r_r    <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (bus.flush) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r     <= bus.op;
                        tag_r    <= bus.tag_in;
                        sign_q_r <= dvd_neg_s ^ dvs_neg_s;
                        sign_r_r <= dvd_neg_s;
                        rem_r    <= {XLEN{1'b0}};
                        quo_r    <= dvd_mag_s;
                        dvs_r    <= dvs_mag_s;
                        cnt_r    <= CNT_W'(XLEN - 1);
                        if (div_zero_s || overflow_s) begin
                            result_r  <= special_res_s;
                            tag_out_r <= bus.tag_in;
                            state_r   <= DONE;
                        end else begin
                            state_r   <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    rem_r <= diff_s[XLEN] ? shift_s[XLEN-1:0] : diff_s[XLEN-1:0];
                    quo_r <= {quo_r[XLEN-2:0], !diff_s[XLEN]};
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    result_r  <= op_r[1] ? rem_fix_s : quo_fix_s;
                    tag_out_r <= tag_r;
                    state_r   <= DONE;
                end
                DONE: begin
                    out_valid_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, arithmetic, special cases, flush,
// back-to-back issue and mid-operation reset.
module tb_div_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [31:0] last_res;
    logic [31:0] last_tag;

    div_unit_if #(.XLEN(32), .TAG_W(5)) bus();

    div_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present an operation (at posedge+1) and let the next edge accept it.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input string name);
        bus.op       = o;
        bus.dividend = a;
        bus.divisor  = b;
        bus.tag_in   = t;
        bus.in_valid = 1'b1;
        chk({name, " in_ready before accept"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = 32'h0000_0001;
        bus.op       = ~o;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input int exp_lat, input logic [31:0] exp_res,
                          input string name);
        int n;
        int busy_bad;
        issue(o, a, b, t, name);
        n = 0;
        busy_bad = 0;
        while (!bus.out_valid && n < 60) begin
            if (bus.in_ready) busy_bad++;
            @(posedge clk); #1;
            n++;
        end
        chk({name, " latency"}, n, exp_lat);
        chk({name, " result"}, bus.result, exp_res);
        chk({name, " tag_out"}, {27'd0, bus.tag_out}, {27'd0, t});
        chk({name, " in_ready low while busy"}, busy_bad, 32'd0);
        @(posedge clk); #1;
        chk({name, " pulse one cycle"}, {31'd0, bus.out_valid}, 32'd0);
        last_res = exp_res;
        last_tag = {27'd0, t};
    endtask

    initial begin
        int pulses;
        int first_acc;
        int second_acc;
        int first_seen;
        logic rdy;
        n_checks = 0;
        n_fail   = 0;
        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        bus.tag_in   = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset result", bus.result, 32'd0);
        chk("reset tag_out", {27'd0, bus.tag_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b01, 32'd100, 32'd7, 5'd5, 34, 32'd14, "DIVU 100/7");
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd6, 34, 32'hFFFF_FFF2, "DIV -100/7");
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd7, 34, 32'hFFFF_FFFE, "REM -100/7");
        run_op(2'b11, 32'hFFFF_FFFF, 32'd16, 5'd8, 34, 32'd15, "REMU ffffffff/16");
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd9, 34, 32'hFFFF_FFFD, "DIV 7/-2");
        run_op(2'b00, 32'd42, 32'd0, 5'd10, 1, 32'hFFFF_FFFF, "DIV 42/0");
        run_op(2'b10, 32'd42, 32'd0, 5'd11, 1, 32'd42, "REM 42/0");
        run_op(2'b01, 32'd5, 32'd0, 5'd12, 1, 32'hFFFF_FFFF, "DIVU 5/0");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1, 32'h8000_0000, "DIV overflow");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1, 32'd0, "REM overflow");
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 34, 32'd0, "DIVU 80000000/ffffffff");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 34, 32'h8000_0000, "REMU 80000000/ffffffff");

        // Flush in the middle of CALC.
        issue(2'b01, 32'd1000, 32'd3, 5'd20, "flush DIVU 1000/3");
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        #1;
        chk("flush in_ready during flush", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        #1;
        chk("flush in_ready next cycle", {31'd0, bus.in_ready}, 32'd1);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        chk("flush no out_valid", pulses, 32'd0);
        chk("flush result kept", bus.result, last_res);
        chk("flush tag_out kept", {27'd0, bus.tag_out}, last_tag);
        run_op(2'b01, 32'd9, 32'd3, 5'd21, 34, 32'd3, "DIVU 9/3 after flush");

        // Back-to-back issue with in_valid held high; operands change after first accept.
        bus.op       = 2'b01;
        bus.dividend = 32'd20;
        bus.divisor  = 32'd4;
        bus.tag_in   = 5'd1;
        bus.in_valid = 1'b1;
        first_acc  = -1;
        second_acc = -1;
        first_seen = 0;
        for (int k = 1; k <= 45 && second_acc < 0; k++) begin
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                if (first_acc < 0) begin
                    first_acc    = k;
                    bus.dividend = 32'd30;
                    bus.divisor  = 32'd5;
                    bus.tag_in   = 5'd2;
                end else begin
                    second_acc = k;
                end
            end
            if (bus.out_valid) begin
                first_seen++;
                chk("b2b first result", bus.result, 32'd5);
                chk("b2b first tag", {27'd0, bus.tag_out}, 32'd1);
            end
        end
        bus.in_valid = 1'b0;
        chk("b2b first result pulses", first_seen, 32'd1);
        chk("b2b acceptance spacing", second_acc - first_acc, 32'd35);

        // Reset pulse at CALC cycle 20 of the second operation.
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid reset result", bus.result, 32'd0);
        chk("mid reset tag_out", {27'd0, bus.tag_out}, 32'd0);
        chk("mid reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        chk("mid reset no pulse", pulses, 32'd0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd3, 34, 32'd1, "REM 7/-2 after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
